teg_cc_ctrl: RTL and testbench

- Lookup/refill sequencer for the 64-entry direct-mapped tag store (6-bit index, one registered read port, write when enable high).
- Accepts CPU-side line lookups, reads and compares the tag, and reports hit or miss.
- On a miss, requests a line refill from the memory side, then writes the new tag back.
- Owns tag-store initialisation after reset and whole-cache flush (invalidate sweep).

---
 rtl/teg_cc_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_teg_cc_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/teg_cc_ctrl.sv
// Lookup/refill sequencer for a 64-entry direct-mapped tag store: init sweep, hit/miss lookup, refill and flush.
// Optional hit/miss statistics counters are enabled with `define YSYX22040228_CC_STAT_EN.
module teg_cc_ctrl #(
    parameter int ADDR_W = 64,
    parameter int IDX_W  = 6,
    parameter int OFF_W  = 4,
    parameter int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              refill_req,
    output logic [ADDR_W-1:0] refill_addr,
    input  logic              refill_ack,
    input  logic              flush_i,
    output logic              flush_done,
    output logic [IDX_W-1:0]  tag_addr_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              tag_valid_o,
    output logic              tag_ena_o,
    input  logic [TAG_W-1:0]  tag_data_i,
`ifdef YSYX22040228_CC_STAT_EN
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
`endif
    input  logic              tag_data_valid_i
);

    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_MISS   = 3'd3,
        ST_FILL   = 3'd4,
        ST_RESP   = 3'd5,
        ST_FLUSH  = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                flush_pend_q, flush_pend_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_hit_q, resp_hit_d;
    logic                refill_req_q, refill_req_d;
    logic [ADDR_W-1:0]   refill_addr_q, refill_addr_d;
    logic                flush_done_q, flush_done_d;
    logic [IDX_W-1:0]    tag_idx_q, tag_idx_d;
    logic [TAG_W-1:0]    tag_wdata_q, tag_wdata_d;
    logic                tag_valid_q, tag_valid_d;
    logic                tag_ena_q, tag_ena_d;

    logic [TAG_W-1:0]    lookup_tag_s;
    logic [IDX_W-1:0]    lookup_idx_s;
    logic                hit_s;

    assign lookup_tag_s = addr_q[ADDR_W-1 -: TAG_W];
    assign lookup_idx_s = addr_q[OFF_W +: IDX_W];
    assign hit_s        = tag_data_valid_i && (tag_data_i == lookup_tag_s);

    // The index goes out combinationally on accept so the registered read lands in LOOKUP.
    assign req_ready   = (state_q == ST_IDLE) && !flush_pend_q && !flush_i;
    assign tag_addr_o  = (state_q == ST_IDLE) ? req_addr[OFF_W +: IDX_W] : tag_idx_q;
    assign resp_valid  = resp_valid_q;
    assign resp_hit    = resp_hit_q;
    assign refill_req  = refill_req_q;
    assign refill_addr = refill_addr_q;
    assign flush_done  = flush_done_q;
    assign tag_o       = tag_wdata_q;
    assign tag_valid_o = tag_valid_q;
    assign tag_ena_o   = tag_ena_q;

    // Next-state and next-output decode; outputs register the action of the state being entered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        flush_pend_d  = flush_pend_q;
        resp_valid_d  = 1'b0;
        resp_hit_d    = 1'b0;
        refill_req_d  = 1'b0;
        refill_addr_d = refill_addr_q;
        flush_done_d  = 1'b0;
        tag_idx_d     = tag_idx_q;
        tag_wdata_d   = {TAG_W{1'b0}};
        tag_valid_d   = 1'b0;
        tag_ena_d     = 1'b0;

        case (state_q)
            ST_INIT, ST_FLUSH: begin
                // Counter MSB set means index 63 has been written; one extra cycle returns to IDLE.
                if (cnt_q[IDX_W] == 1'b0) begin
                    tag_ena_d = 1'b1;
                    tag_idx_d = cnt_q[IDX_W-1:0];
                    cnt_d     = cnt_q + CNT_W'(1);
                end else begin
                    state_d      = ST_IDLE;
                    cnt_d        = {CNT_W{1'b0}};
                    flush_done_d = (state_q == ST_FLUSH);
                end
            end
            ST_IDLE: begin
                if (flush_i || flush_pend_q) begin
                    state_d      = ST_FLUSH;
                    cnt_d        = {CNT_W{1'b0}};
                    flush_pend_d = 1'b0;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                flush_pend_d = flush_pend_q || flush_i;
                if (hit_s) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                end else begin
                    state_d       = ST_MISS;
                    refill_req_d  = 1'b1;
                    refill_addr_d = {lookup_tag_s, lookup_idx_s, {OFF_W{1'b0}}};
                end
            end
            ST_MISS: begin
                flush_pend_d = flush_pend_q || flush_i;
                if (refill_ack) begin
                    state_d     = ST_FILL;
                    tag_ena_d   = 1'b1;
                    tag_idx_d   = lookup_idx_s;
                    tag_wdata_d = lookup_tag_s;
                    tag_valid_d = 1'b1;
                end else begin
                    refill_req_d = 1'b1;
                end
            end
            ST_FILL: begin
                flush_pend_d = flush_pend_q || flush_i;
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                flush_pend_d = flush_pend_q || flush_i;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, sweep counter, latched request and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_INIT;
            cnt_q         <= {CNT_W{1'b0}};
            addr_q        <= {ADDR_W{1'b0}};
            flush_pend_q  <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            refill_req_q  <= 1'b0;
            refill_addr_q <= {ADDR_W{1'b0}};
            flush_done_q  <= 1'b0;
            tag_idx_q     <= {IDX_W{1'b0}};
            tag_wdata_q   <= {TAG_W{1'b0}};
            tag_valid_q   <= 1'b0;
            tag_ena_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            flush_pend_q  <= flush_pend_d;
            resp_valid_q  <= resp_valid_d;
            resp_hit_q    <= resp_hit_d;
            refill_req_q  <= refill_req_d;
            refill_addr_q <= refill_addr_d;
            flush_done_q  <= flush_done_d;
            tag_idx_q     <= tag_idx_d;
            tag_wdata_q   <= tag_wdata_d;
            tag_valid_q   <= tag_valid_d;
            tag_ena_q     <= tag_ena_d;
        end
    end

`ifdef YSYX22040228_CC_STAT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

    // Saturating hit/miss counters, cleared when a flush sweep completes.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (flush_done_d) begin
            hit_cnt_d  = 32'd0;
            miss_cnt_d = 32'd0;
        end else if (resp_valid_q && resp_hit_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (resp_valid_q && !resp_hit_q && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end else begin
            hit_cnt_d  = hit_cnt_q;
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_teg_cc_ctrl.sv
// Directed bench for teg_cc_ctrl with a behavioural 64-entry tag store (registered read).
module tb_teg_cc_ctrl;

    localparam int ADDR_W = 64;
    localparam int IDX_W  = 6;
    localparam int OFF_W  = 4;
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_hit;
    logic              refill_req;
    logic [ADDR_W-1:0] refill_addr;
    logic              refill_ack;
    logic              flush_i;
    logic              flush_done;
    logic [IDX_W-1:0]  tag_addr_o;
    logic [TAG_W-1:0]  tag_o;
    logic              tag_valid_o;
    logic              tag_ena_o;
    logic [TAG_W-1:0]  tag_data_i;
    logic              tag_data_valid_i;
`ifdef YSYX22040228_CC_STAT_EN
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;
`endif

    int n_checks;
    int n_fail;

    logic [TAG_W-1:0]  mem_tag [64];
    logic              mem_v   [64];

    teg_cc_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_hit(resp_hit),
        .refill_req(refill_req), .refill_addr(refill_addr), .refill_ack(refill_ack),
        .flush_i(flush_i), .flush_done(flush_done),
        .tag_addr_o(tag_addr_o), .tag_o(tag_o), .tag_valid_o(tag_valid_o), .tag_ena_o(tag_ena_o),
        .tag_data_i(tag_data_i),
`ifdef YSYX22040228_CC_STAT_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .tag_data_valid_i(tag_data_valid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tag store: write when enabled, read data registered one cycle.
    always @(posedge clk) begin
        if (tag_ena_o) begin
            mem_tag[tag_addr_o] <= tag_o;
            mem_v[tag_addr_o]   <= tag_valid_o;
        end
        tag_data_i       <= mem_tag[tag_addr_o];
        tag_data_valid_i <= mem_v[tag_addr_o];
    end

    task automatic run_req(input logic [ADDR_W-1:0] addr, input int ack_delay, input bit pulse_flush,
                           output int lat, output bit hit, output bit saw_refill,
                           output logic [ADDR_W-1:0] raddr, output bit stable, output bit timeout);
        int  rcyc;
        bit  done;
        lat = 0; hit = 1'b0; saw_refill = 1'b0; raddr = '0; stable = 1'b1; timeout = 1'b0;
        rcyc = 0; done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        for (int w = 0; w < 200 && !req_ready; w++) @(negedge clk);
        if (!req_ready) begin
            req_valid = 1'b0;
            timeout   = 1'b1;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 300) begin
            if (refill_req) begin
                if (!saw_refill) begin
                    raddr      = refill_addr;
                    saw_refill = 1'b1;
                    flush_i    = pulse_flush;
                end else begin
                    if (refill_addr !== raddr) stable = 1'b0;
                    flush_i = 1'b0;
                end
                refill_ack = (rcyc == ack_delay);
                rcyc++;
            end else begin
                refill_ack = 1'b0;
                flush_i    = 1'b0;
            end
            if (resp_valid) begin
                hit  = resp_hit;
                done = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        refill_ack = 1'b0;
        flush_i    = 1'b0;
        if (!done) timeout = 1'b1;
    endtask

    task automatic observe_flush(output int writes, output bit seq_ok, output bit ready_early,
                                 output bit ready_at_done, output bit got_done, output bit single_pulse);
        writes = 0; seq_ok = 1'b1; ready_early = 1'b0; ready_at_done = 1'b0;
        got_done = 1'b0; single_pulse = 1'b0;
        for (int i = 0; i < 300 && !got_done; i++) begin
            @(negedge clk);
            if (flush_done) begin
                got_done      = 1'b1;
                ready_at_done = req_ready;
            end else begin
                if (tag_ena_o) begin
                    if (tag_addr_o !== writes[IDX_W-1:0] || tag_valid_o !== 1'b0) seq_ok = 1'b0;
                    writes++;
                end
                if (req_ready) ready_early = 1'b1;
            end
        end
        if (got_done) begin
            @(negedge clk);
            single_pulse = !flush_done;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; refill_ack = 1'b0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, resp_hit, refill_req, flush_done, tag_ena_o, tag_valid_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {req_ready, resp_valid, resp_hit, refill_req, flush_done, tag_ena_o, tag_valid_o});
        end
        n_checks++;
        if (tag_addr_o !== 6'd0 || tag_o !== 54'd0 || refill_addr !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data: got addr %h tag %h raddr %h expected all 0", tag_addr_o, tag_o, refill_addr);
        end
    endtask

    task automatic test_init;
        logic [9:0] got;
        logic [9:0] exp;
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            got = {tag_ena_o, tag_valid_o, req_ready, flush_done, tag_addr_o};
            exp = {4'b1000, 6'(i)};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL init_write[%0d]: got {ena,valid,ready,done,addr}=%b expected %b", i, got, exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({tag_ena_o, req_ready, flush_done} !== 3'b010) begin
            n_fail++;
            $display("FAIL init_end: got {ena,ready,done}=%b expected 010", {tag_ena_o, req_ready, flush_done});
        end
    endtask

    task automatic test_miss_fill;
        int lat; bit hit, sr, st, to; logic [ADDR_W-1:0] ra;
        run_req(64'h8000_1230, 5, 1'b0, lat, hit, sr, ra, st, to);
        n_checks++;
        if (to || hit !== 1'b0 || lat != 9) begin
            n_fail++;
            $display("FAIL miss_resp: got timeout %0d hit %0d lat %0d expected 0 0 9", to, hit, lat);
        end
        n_checks++;
        if (!sr || ra !== 64'h8000_1230 || !st) begin
            n_fail++;
            $display("FAIL miss_refill: got seen %0d addr %h stable %0d expected 1 80001230 1", sr, ra, st);
        end
        n_checks++;
        if (mem_tag[35] !== 54'h200004 || mem_v[35] !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_fill_write: got tag %h v %0d expected 200004 1", mem_tag[35], mem_v[35]);
        end
    endtask

    task automatic test_hit;
        int lat; bit hit, sr, st, to; logic [ADDR_W-1:0] ra;
        run_req(64'h8000_1238, 0, 1'b0, lat, hit, sr, ra, st, to);
        n_checks++;
        if (to || hit !== 1'b1 || lat != 2 || sr) begin
            n_fail++;
            $display("FAIL hit_resp: got timeout %0d hit %0d lat %0d refill %0d expected 0 1 2 0", to, hit, lat, sr);
        end
    endtask

    task automatic test_conflict;
        int lat; bit hit, sr, st, to; logic [ADDR_W-1:0] ra;
        run_req(64'h9000_1230, 2, 1'b0, lat, hit, sr, ra, st, to);
        n_checks++;
        if (to || hit !== 1'b0 || lat != 6 || ra !== 64'h9000_1230 || !st) begin
            n_fail++;
            $display("FAIL conflict_miss: got hit %0d lat %0d raddr %h expected 0 6 90001230", hit, lat, ra);
        end
        n_checks++;
        if (mem_tag[35] !== 54'h240004 || mem_v[35] !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict_write: got tag %h v %0d expected 240004 1", mem_tag[35], mem_v[35]);
        end
        run_req(64'h8000_1230, 0, 1'b0, lat, hit, sr, ra, st, to);
        n_checks++;
        if (to || hit !== 1'b0 || lat != 4 || ra !== 64'h8000_1230) begin
            n_fail++;
            $display("FAIL evicted_miss: got hit %0d lat %0d raddr %h expected 0 4 80001230", hit, lat, ra);
        end
    endtask

    task automatic test_flush_during_miss;
        int lat; bit hit, sr, st, to; logic [ADDR_W-1:0] ra;
        int wr; bit sq, re, rd, gd, sp;
        run_req(64'h1234_5670, 3, 1'b1, lat, hit, sr, ra, st, to);
        n_checks++;
        if (to || hit !== 1'b0 || lat != 7 || ra !== 64'h1234_5670) begin
            n_fail++;
            $display("FAIL flush_miss_resp: got hit %0d lat %0d raddr %h expected 0 7 12345670", hit, lat, ra);
        end
`ifdef YSYX22040228_CC_STAT_EN
        @(negedge clk);
        n_checks++;
        if (hit_cnt !== 32'd1 || miss_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL stats_before_flush: got hit %0d miss %0d expected 1 4", hit_cnt, miss_cnt);
        end
`endif
        observe_flush(wr, sq, re, rd, gd, sp);
        n_checks++;
        if (wr != 64 || !sq || re || !gd || !sp || !rd) begin
            n_fail++;
            $display("FAIL flush_sweep: got writes %0d seq %0d early_ready %0d done %0d pulse %0d ready %0d expected 64 1 0 1 1 1",
                     wr, sq, re, gd, sp, rd);
        end
`ifdef YSYX22040228_CC_STAT_EN
        n_checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_after_flush: got hit %0d miss %0d expected 0 0", hit_cnt, miss_cnt);
        end
`endif
        run_req(64'h8000_1230, 0, 1'b0, lat, hit, sr, ra, st, to);
        n_checks++;
        if (to || hit !== 1'b0 || !sr) begin
            n_fail++;
            $display("FAIL post_flush_miss: got hit %0d refill %0d expected 0 1", hit, sr);
        end
    endtask

    task automatic test_flush_collision;
        int wr; bit sq, re, rd, gd, sp, done, sr;
        logic [ADDR_W-1:0] ra;
        @(negedge clk);
        flush_i   = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'h9000_1230;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_ready: got %0d expected 0", req_ready);
        end
        @(negedge clk);
        flush_i = 1'b0;
        observe_flush(wr, sq, re, rd, gd, sp);
        req_valid = 1'b0;
        n_checks++;
        if (wr != 64 || !sq || re || !gd || !sp || !rd) begin
            n_fail++;
            $display("FAIL collide_sweep: got writes %0d seq %0d early_ready %0d done %0d pulse %0d ready %0d expected 64 1 0 1 1 1",
                     wr, sq, re, gd, sp, rd);
        end
        done = 1'b0; sr = 1'b0; ra = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            refill_ack = refill_req;
            if (refill_req && !sr) begin
                sr = 1'b1;
                ra = refill_addr;
            end
            if (resp_valid) done = 1'b1;
        end
        refill_ack = 1'b0;
        n_checks++;
        if (!done || resp_hit !== 1'b0 || !sr || ra !== 64'h9000_1230) begin
            n_fail++;
            $display("FAIL collide_req: got done %0d hit %0d refill %0d raddr %h expected 1 0 1 90001230",
                     done, resp_hit, sr, ra);
        end
`ifdef YSYX22040228_CC_STAT_EN
        @(negedge clk);
        n_checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL stats_final: got hit %0d miss %0d expected 0 1", hit_cnt, miss_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_refill;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 64'hA000_0040;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = refill_req;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midreset_refill_seen: got 0 expected 1");
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({refill_req, resp_valid, tag_ena_o, req_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got {refill,resp,ena,ready}=%b expected 0000",
                     {refill_req, resp_valid, tag_ena_o, req_ready});
        end
        @(negedge clk);
        test_init();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_init();
        test_miss_fill();
        test_hit();
        test_conflict();
        test_flush_during_miss();
        test_flush_collision();
        test_reset_mid_refill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
